// File: rtl/bcd_scan_driver_pkg.sv
// Shared display constants for the multiplexed BCD scan driver and the
// seven-segment decoder downstream of it.
package bcd_scan_driver_pkg;

   localparam logic [3:0] BLANK_CODE         = 4'hF;
   localparam int         DEFAULT_NUM_DIGITS = 4;
   localparam int         DEFAULT_SCAN_DIV   = 1000;

   // A zero nibble is blankable only when every nibble above it is also zero.
   function automatic logic nibble_is_zero(input logic [3:0] nib);
      return (nib == 4'h0);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-dwell prescaler: counts 0..SCAN_DIV-1 and wraps; tick_o is high
// for the single cycle in which the count sits at SCAN_DIV-1.
module scan_prescaler
   import bcd_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST);

endmodule

// File: rtl/bcd_scan_driver.sv
// Multiplexed BCD display scanner with frame-synchronous double buffering
// and optional leading-zero blanking; all outputs are registered.
module bcd_scan_driver
   import bcd_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
   parameter int SCAN_DIV   = DEFAULT_SCAN_DIV
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    lz_blank,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int            DW       = 4 * NUM_DIGITS;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   logic                  tick;
   logic                  boundary;
   logic [IW-1:0]         idx_q,      idx_d;
   logic [DW-1:0]         active_q,   active_d;
   logic [DW-1:0]         pending_q,  pending_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [3:0]            bcd_q,      bcd_d;
   logic [NUM_DIGITS-1:0] en_q,       en_d;
   logic                  done_q,     done_d;
   logic [NUM_DIGITS-1:0] lead_zero;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_prescaler (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tick_o (tick)
   );

   // The boundary is the tick that wraps the index; the outputs registered
   // at that edge are the first cycle of the new frame.
   assign boundary = tick && (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      active_d   = active_q;
      pending_d  = pending_q;
      pend_vld_d = pend_vld_q;
      if (boundary) begin
         if (load) begin
            active_d   = digits_in;
            pend_vld_d = 1'b0;
         end else if (pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
         end
      end else if (load) begin
         pending_d  = digits_in;
         pend_vld_d = 1'b1;
      end
   end

   // Scan from the top nibble down; digit 0 is never marked as a leading zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lead_zero  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && nibble_is_zero(active_d[4*i +: 4]);
         if (i != 0) begin
            lead_zero[i] = zero_above;
         end
      end
   end

   always_comb begin
      bcd_d = BLANK_CODE;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            bcd_d = (lz_blank && lead_zero[i]) ? BLANK_CODE : active_d[4*i +: 4];
         end
      end
   end

   assign en_d   = NUM_DIGITS'(1) << idx_d;
   assign done_d = boundary;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q      <= '0;
         active_q   <= {NUM_DIGITS{BLANK_CODE}};
         pending_q  <= '0;
         pend_vld_q <= 1'b0;
         bcd_q      <= BLANK_CODE;
         en_q       <= NUM_DIGITS'(1);
         done_q     <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         pend_vld_q <= pend_vld_d;
         bcd_q      <= bcd_d;
         en_q       <= en_d;
         done_q     <= done_d;
      end
   end

   assign bcd_out    = bcd_q;
   assign digit_en   = en_q;
   assign frame_done = done_q;

endmodule
